control_step_sequencer: RTL and testbench

Hardware control unit that replaces bench-driven T-step control of the datapath. It sequences fetch, decode and execute for register-register ALU, multiply/divide and unary instructions, and drives the datapath's bus-out and register-in enables, ALU op selects and memory read strobe. It supports parametrised register-file size and memory wait states, plus single-step or continuous-run modes.

---
 rtl/control_step_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_control_step_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/control_step_sequencer.sv
// control_step_sequencer: hardwired T-step control unit. Sequences fetch,
// decode and execute for register-register ALU, multiply/divide and unary
// instructions, and drives the datapath strobes as a Moore decode of the
// current step and the latched instruction.
module control_step_sequencer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  localparam int NUM_REGS  = 2**REG_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir_in,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                LOin,
  output logic                HIin,
  output logic [12:0]         alu_op,
  output logic [3:0]          state,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_ILL = 4'd8
  } state_t;

  typedef enum logic [1:0] {K_ILL, K_BIN, K_MULDIV, K_UNARY} kind_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;

  kind_t             w_kind;
  logic [12:0]       w_alu;
  logic [NUM_REGS-1:0] w_ra, w_rb, w_rc;
  logic              w_unused_ir;

  function automatic kind_t f_kind(input logic [4:0] op);
    kind_t k;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL: k = K_BIN;
      OP_MUL, OP_DIV:          k = K_MULDIV;
      OP_NEG, OP_NOT:          k = K_UNARY;
      default:                 k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [12:0] f_alu(input logic [4:0] op);
    logic [12:0] a;
    a = '0;
    case (op)
      OP_AND:  a[0]  = 1'b1;
      OP_OR:   a[1]  = 1'b1;
      OP_ADD:  a[2]  = 1'b1;
      OP_SUB:  a[3]  = 1'b1;
      OP_MUL:  a[4]  = 1'b1;
      OP_DIV:  a[5]  = 1'b1;
      OP_SHR:  a[6]  = 1'b1;
      OP_SHRA: a[7]  = 1'b1;
      OP_SHL:  a[8]  = 1'b1;
      OP_ROR:  a[9]  = 1'b1;
      OP_ROL:  a[10] = 1'b1;
      OP_NEG:  a[11] = 1'b1;
      OP_NOT:  a[12] = 1'b1;
      default: a = '0;
    endcase
    return a;
  endfunction

  // Field values outside the register file decode to no select at all.
  function automatic logic [NUM_REGS-1:0] f_onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if ({28'd0, idx} == i) v[i] = 1'b1;
    return v;
  endfunction

  assign w_kind      = f_kind(r_ir[31:27]);
  assign w_alu       = f_alu(r_ir[31:27]);
  assign w_ra        = f_onehot(r_ir[26:23]);
  assign w_rb        = f_onehot(r_ir[22:19]);
  assign w_rc        = f_onehot(r_ir[18:15]);
  assign w_unused_ir = ^r_ir[14:0];
  assign state       = r_state;

  // Step register and instruction latch; T2 branches on the incoming word
  // because r_ir only holds it from T3 onward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (mem_ready) r_state <= S_T2;
        S_T2: begin
          r_ir <= ir_in;
          case (f_kind(ir_in[31:27]))
            K_BIN, K_MULDIV: r_state <= S_T3;
            K_UNARY:         r_state <= S_T4;
            default:         r_state <= S_ILL;
          endcase
        end
        S_T3:   r_state <= S_T4;
        S_T4:   r_state <= S_T5;
        S_T5: begin
          if (w_kind == K_MULDIV) r_state <= S_T6;
          else                    r_state <= run ? S_T0 : S_IDLE;
        end
        S_T6, S_ILL: r_state <= run ? S_T0 : S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of datapath strobes from the current step and r_ir.
  always_comb begin
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = '0;
    PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; PCin = 1'b0;
    Read  = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin   = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    LOin  = 1'b0; HIin = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Yin = 1'b1;
        reg_out_sel = (w_kind == K_MULDIV) ? w_ra : w_rb;
      end
      S_T4: begin
        Zin    = 1'b1;
        alu_op = w_alu;
        reg_out_sel = (w_kind == K_BIN) ? w_rc : w_rb;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_kind == K_MULDIV) begin
          LOin = 1'b1;
        end else begin
          reg_in_sel = w_ra;
          done       = 1'b1;
        end
      end
      S_T6:  begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
      S_ILL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed-vector bench for control_step_sequencer with hand-computed
// expected step outputs.
module tb_control_step_sequencer;

  logic        clk, reset, start, run, mem_ready;
  logic [31:0] ir_in;
  logic [15:0] reg_out_sel, reg_in_sel;
  logic PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [12:0] alu_op;
  logic [3:0]  state;
  logic        busy, done, illegal;
  logic [13:0] strb;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [13:0] B_PCOUT = 14'h2000, B_INCPC = 14'h1000,
    B_MARIN = 14'h0800, B_PCIN = 14'h0400, B_READ = 14'h0200,
    B_MDRIN = 14'h0100, B_MDROUT = 14'h0080, B_IRIN = 14'h0040,
    B_YIN = 14'h0020, B_ZIN = 14'h0010, B_ZLO = 14'h0008,
    B_ZHI = 14'h0004, B_LOIN = 14'h0002, B_HIIN = 14'h0001;
  localparam logic [13:0] ST0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [13:0] ST1 = B_ZLO | B_PCIN | B_READ | B_MDRIN;
  localparam logic [13:0] ST2 = B_MDROUT | B_IRIN;

  localparam logic [31:0] I_SHRA = 32'h521B8000;  // Ra=4 Rb=3 Rc=7
  localparam logic [31:0] I_MUL  = 32'h79280000;  // Ra=2 Rb=5
  localparam logic [31:0] I_ADD  = 32'h18918000;  // Ra=1 Rb=2 Rc=3
  localparam logic [31:0] I_ILL  = 32'hF8000000;

  assign strb = {PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin,
                 Yin, Zin, Zlowout, Zhighout, LOin, HIin};

  control_step_sequencer #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run),
    .mem_ready(mem_ready), .ir_in(ir_in),
    .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .alu_op(alu_op), .state(state),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input string tag, input logic [3:0] st,
                             input logic [15:0] ros, input logic [15:0] ris,
                             input logic [12:0] alu, input logic [13:0] s,
                             input logic dn, input logic il);
    check({tag, ".state"},   {28'd0, state},      {28'd0, st});
    check({tag, ".ros"},     {16'd0, reg_out_sel}, {16'd0, ros});
    check({tag, ".ris"},     {16'd0, reg_in_sel},  {16'd0, ris});
    check({tag, ".alu"},     {19'd0, alu_op},      {19'd0, alu});
    check({tag, ".strb"},    {18'd0, strb},        {18'd0, s});
    check({tag, ".done"},    {31'd0, done},        {31'd0, dn});
    check({tag, ".illegal"}, {31'd0, illegal},     {31'd0, il});
    check({tag, ".busy"},    {31'd0, busy},        {31'd0, (st != 4'd0)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ndone, nbusy_lo;

    // Reset with random inputs
    reset = 1'b0; start = 1'b0; run = 1'b0; mem_ready = 1'b0; ir_in = '0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); run = 1'($urandom);
      mem_ready = 1'($urandom); ir_in = $urandom;
      tick();
      expect_step("rst", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    end
    start = 1'b0; run = 1'b0; mem_ready = 1'b1; ir_in = '0;
    reset = 1'b1;
    tick();
    expect_step("idle", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);

    // SHRA, start held across the fetch steps (must not re-trigger)
    ir_in = I_SHRA; start = 1'b1;
    tick(); expect_step("shra.t0", 4'd1, '0, '0, '0, ST0, 1'b0, 1'b0);
    tick(); expect_step("shra.t1", 4'd2, '0, '0, '0, ST1, 1'b0, 1'b0);
    tick(); expect_step("shra.t2", 4'd3, '0, '0, '0, ST2, 1'b0, 1'b0);
    tick(); expect_step("shra.t3", 4'd4, 16'h0008, '0, '0, B_YIN, 1'b0, 1'b0);
    start = 1'b0;
    tick(); expect_step("shra.t4", 4'd5, 16'h0080, '0, 13'h0080, B_ZIN, 1'b0, 1'b0);
    tick(); expect_step("shra.t5", 4'd6, '0, 16'h0010, '0, B_ZLO, 1'b1, 1'b0);
    tick(); expect_step("shra.end", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Wait states: three mem_ready=0 samples in T1
    mem_ready = 1'b0; start = 1'b1;
    tick(); cyc = 1; start = 1'b0;
    expect_step("ws.t0", 4'd1, '0, '0, '0, ST0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); cyc++;
      expect_step("ws.t1", 4'd2, '0, '0, '0, ST1, 1'b0, 1'b0);
      if (i == 3) mem_ready = 1'b1;
    end
    while (!done && cyc < 20) begin
      tick(); cyc++;
    end
    check("ws.latency", cyc, 9);
    check("ws.ris", {16'd0, reg_in_sel}, 32'h0010);
    tick();
    expect_step("ws.end", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);

    // MUL
    ir_in = I_MUL; start = 1'b1;
    tick(); start = 1'b0;
    expect_step("mul.t0", 4'd1, '0, '0, '0, ST0, 1'b0, 1'b0);
    tick(); tick();
    expect_step("mul.t2", 4'd3, '0, '0, '0, ST2, 1'b0, 1'b0);
    tick(); expect_step("mul.t3", 4'd4, 16'h0004, '0, '0, B_YIN, 1'b0, 1'b0);
    tick(); expect_step("mul.t4", 4'd5, 16'h0020, '0, 13'h0010, B_ZIN, 1'b0, 1'b0);
    tick(); expect_step("mul.t5", 4'd6, '0, '0, '0, B_ZLO | B_LOIN, 1'b0, 1'b0);
    tick(); expect_step("mul.t6", 4'd7, '0, '0, '0, B_ZHI | B_HIIN, 1'b1, 1'b0);
    tick(); expect_step("mul.end", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset in T4, then a normal fetch
    ir_in = I_ADD; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    expect_step("rstm.t4", 4'd5, 16'h0008, '0, 13'h0004, B_ZIN, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    expect_step("rstm.async", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    reset = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    expect_step("rstm.t0", 4'd1, '0, '0, '0, ST0, 1'b0, 1'b0);
    tick(); tick(); tick();
    expect_step("add.t3", 4'd4, 16'h0004, '0, '0, B_YIN, 1'b0, 1'b0);
    tick(); tick();
    expect_step("add.t5", 4'd6, '0, 16'h0002, '0, B_ZLO, 1'b1, 1'b0);
    tick();

    // Illegal opcode in continuous mode
    ir_in = I_ILL; run = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    expect_step("ill.ill", 4'd8, '0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    expect_step("ill.t0", 4'd1, '0, '0, '0, ST0, 1'b0, 1'b0);
    run = 1'b0;
    tick(); tick(); tick();
    expect_step("ill.ill2", 4'd8, '0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    expect_step("ill.end", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Continuous run, two ADDs back to back
    ir_in = I_ADD; run = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    ndone = 0; nbusy_lo = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) ndone++;
      if (!busy) nbusy_lo++;
      if (c == 6)  check("cont.t5a", {28'd0, state}, 32'd6);
      if (c == 7)  begin check("cont.t0b", {28'd0, state}, 32'd1); run = 1'b0; end
      if (c == 12) check("cont.t5b", {28'd0, state}, 32'd6);
      if (c < 12) tick();
    end
    check("cont.done_count", ndone, 2);
    check("cont.busy_low", nbusy_lo, 0);
    tick();
    expect_step("cont.end", 4'd0, '0, '0, '0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
